seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for scan_clk (legal range 2..3).
REQ-002 SHALL have port clock_in, input, 1, the system clock; all flops clock on its rising edge.
REQ-003 SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-004 SHALL have port scan_clk, input, 1, the divided clock from the clock divider, treated as asynchronous data.
REQ-005 SHALL have port enable, input, 1; while high, the block scans the display.
REQ-006 SHALL have port value, input, 16, holding four hex nibbles; digit k = value[4k+3:4k].
REQ-007 SHALL have port dp_en, input, 4; bit k lights the decimal point on digit k.
REQ-008 SHALL have port blank_lz, input, 1; while high, leading zeros are suppressed.
REQ-009 SHALL have port an, output, 4, the active-low digit anodes.
REQ-010 SHALL have port seg, output, 7, active-low cathodes ordered {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp, output, 1, the active-low decimal point.

Function
REQ-012 SHALL pass scan_clk through SYNC_STAGES flops, then one history flop; tick = last sync stage high AND history low.
REQ-013 SHALL assert tick exactly once per scan_clk rising edge; a constant scan_clk, high or low, SHALL produce no tick.
REQ-014 SHALL implement FSM states IDLE and SCAN.
REQ-015 In IDLE, SHALL drive an=4'b1111, seg=7'h7F and dp=1.
REQ-016 IDLE->SCAN on tick with enable=1; on that cycle, SHALL load snapshot<=value and dp_snap<=dp_en, and set idx<=0.
REQ-017 In SCAN, on each tick SHALL advance idx (2-bit); on the 3->0 wrap, SHALL reload snapshot and dp_snap in the same cycle.
REQ-018 The displayed nibble SHALL come only from snapshot, never from live value, so that a full frame is tear-free.
REQ-019 SCAN->IDLE on the first cycle with enable=0; enable SHALL take priority over a simultaneous tick.
REQ-020 The an, seg and dp outputs SHALL be registered and SHALL update one clock_in cycle after the state/idx change.
REQ-021 Total latency from scan_clk rising to the new an/seg SHALL be SYNC_STAGES+2 clock_in cycles.
REQ-022 In SCAN, an SHALL be one-hot-low at position idx; dp = ~dp_snap[idx].
REQ-023 Decode SHALL be standard hex 0-F, e.g. 0->7'h40, 8->7'h00, F->7'h0E.
REQ-024 Blanking: digit k (k=3..1) SHALL be blank (seg=7'h7F, anode still driven) when blank_lz=1 and snapshot nibbles k..3 are all zero.
REQ-025 Digit 0 SHALL never be blanked.
REQ-026 SHALL be insensitive to the scan_clk duty cycle; the minimum scan_clk high and low time is SYNC_STAGES+1 clock_in cycles.

Reset
REQ-027 While reset=1, SHALL set: sync and history flops=0, state=IDLE, idx=0, snapshot=16'h0000, dp_snap=4'h0, an=4'b1111, seg=7'h7F, dp=1.
REQ-028 Reset asserted mid-scan SHALL blank the display immediately (asynchronously).
REQ-029 After reset release, the first tick SHALL restart the scan at digit 0 with a fresh snapshot.

Structure
REQ-030 A shared package seg7_pkg SHALL hold the 16-entry segment pattern constants, SEG_BLANK=7'h7F and AN_OFF=4'b1111.
REQ-031 A sub-module hex_to_seg SHALL implement the combinational 4-bit to 7-segment decode from seg7_pkg; it SHALL be instantiated once.

Verification
REQ-032 value=16'h1234, blank_lz=0, enable=1, 8 scan_clk edges -> an cycles 1110,1101,1011,0111 twice; seg=7'h79,24,30,19 (digits 4,3,2,1 on an[0..3]).
REQ-033 value=16'h00A0, blank_lz=1 -> digits 3,2 blank (seg 7'h7F); digit 1=7'h08 ("A"); digit 0=7'h40.
REQ-034 value=16'h0000, blank_lz=1 -> only digit 0 lit, showing 7'h40.
REQ-035 value changes 16'h1111->16'h2222 while idx=1 -> digits 2,3 still show 7'h79; 7'h24 appears only after the wrap to idx 0.
REQ-036 reset pulsed while idx=2 -> an=4'b1111 within the same cycle, with no dependence on clock_in; first tick after release lights an=1110 SYNC_STAGES+2 cycles later.
REQ-037 enable dropped coincident with tick -> state IDLE, an=4'b1111 next cycle; scan_clk held high 100 cycles -> no idx change.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scanner: segment patterns, blank codes and FSM states.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Entry 15 is written first so that SEG_PATTERNS[n] decodes hex digit n.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

endpackage

// File: rtl/seg7_scan_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern decode.
module hex_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_PATTERNS[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner stepped by an asynchronous scan clock.
// A full frame is taken from a snapshot reloaded only at the digit 3 -> 0 wrap.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        scan_clk,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   tick;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] snap_q, snap_d;
  logic [3:0]  dp_snap_q, dp_snap_d;

  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic [3:0]  nibble;
  logic [6:0]  seg_dec;
  logic        lead_zero;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], scan_clk};
  assign hist_d = sync_q[SYNC_STAGES-1];
  assign tick   = sync_q[SYNC_STAGES-1] & ~hist_q;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    dp_snap_d = dp_snap_q;
    unique case (state_q)
      IDLE: begin
        if (enable && tick) begin
          state_d   = SCAN;
          idx_d     = 2'd0;
          snap_d    = value;
          dp_snap_d = dp_en;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tick) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            snap_d    = value;
            dp_snap_d = dp_en;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign nibble = snap_q[{idx_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    lead_zero = 1'b0;
    unique case (idx_q)
      2'd3:    lead_zero = (snap_q[15:12] == 4'h0);
      2'd2:    lead_zero = (snap_q[15:8]  == 8'h00);
      2'd1:    lead_zero = (snap_q[15:4]  == 12'h000);
      default: lead_zero = 1'b0;
    endcase
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (state_q == SCAN) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = (blank_lz && lead_zero) ? SEG_BLANK : seg_dec;
      dp_d  = ~dp_snap_q[idx_q];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      snap_q    <= 16'h0000;
      dp_snap_q <= 4'h0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      dp_snap_q <= dp_snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: vector table of full frames plus hand-written
// sequences for latency, tear-free reload, asynchronous reset, enable priority and held scan_clk.
module tb_seg7_scan;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        scan_clk;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  always #5 clock_in = ~clock_in;

  seg7_scan #(.SYNC_STAGES(SYNC)) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .scan_clk (scan_clk),
    .enable   (enable),
    .value    (value),
    .dp_en    (dp_en),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  typedef struct {
    logic [15:0]      value;
    logic             blz;
    logic [3:0]       dp_en;
    logic [3:0][6:0]  seg_exp;
    logic [3:0]       dp_exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] an_for(input int k);
    logic [3:0] a;
    a    = 4'b1111;
    a[k] = 1'b0;
    return a;
  endfunction

  task automatic push_exp(input logic [3:0] a, input logic [6:0] s, input logic d);
    exp_t e;
    e.an  = a;
    e.seg = s;
    e.dp  = d;
    sb_q.push_back(e);
  endtask

  task automatic compare_out(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got an=%b seg=%h", name, an, seg);
    end else begin
      e = sb_q.pop_front();
      check({name, ".an"}, 32'(an), 32'(e.an));
      check({name, ".seg"}, 32'(seg), 32'(e.seg));
      check({name, ".dp"}, 32'(dp), 32'(e.dp));
    end
  endtask

  // One scan_clk period; the output is compared exactly LAT cycles after the rising edge.
  task automatic scan_edge(input string name);
    @(negedge clock_in);
    scan_clk = 1'b1;
    repeat (LAT) @(posedge clock_in);
    #1;
    compare_out(name);
    @(negedge clock_in);
    scan_clk = 1'b0;
    repeat (SYNC + 1) @(posedge clock_in);
  endtask

  task automatic go_idle(input string name);
    @(negedge clock_in);
    enable = 1'b0;
    repeat (2) @(posedge clock_in);
    #1;
    check({name, ".an"}, 32'(an), 32'(4'b1111));
    check({name, ".seg"}, 32'(seg), 32'(7'h7F));
  endtask

  task automatic start_frame(input logic [15:0] v, input logic b, input logic [3:0] d);
    @(negedge clock_in);
    value    = v;
    blank_lz = b;
    dp_en    = d;
    enable   = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1234, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    vecs[1] = '{16'h00A0, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h08, 7'h40}, 4'b1110};
    vecs[2] = '{16'h0000, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vecs[3] = '{16'h89EF, 1'b0, 4'b1010, {7'h00, 7'h10, 7'h06, 7'h0E}, 4'b0101};
    vecs[4] = '{16'h0100, 1'b1, 4'b0100, {7'h7F, 7'h79, 7'h40, 7'h40}, 4'b1011};
    vecs[5] = '{16'h0000, 1'b0, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
    vecs[6] = '{16'h5C7D, 1'b1, 4'b1111, {7'h12, 7'h46, 7'h78, 7'h21}, 4'b0000};

    reset    = 1'b1;
    scan_clk = 1'b0;
    enable   = 1'b0;
    value    = 16'h0000;
    dp_en    = 4'h0;
    blank_lz = 1'b0;
    repeat (3) @(posedge clock_in);
    #1;
    check("reset.an", 32'(an), 32'(4'b1111));
    check("reset.seg", 32'(seg), 32'(7'h7F));
    check("reset.dp", 32'(dp), 32'(1'b1));
    @(negedge clock_in);
    reset = 1'b0;
    repeat (2) @(posedge clock_in);

    // First tick after reset: blank for LAT-1 cycles, digit 0 on cycle LAT.
    start_frame(16'h1234, 1'b0, 4'b0000);
    @(negedge clock_in);
    scan_clk = 1'b1;
    repeat (LAT - 1) @(posedge clock_in);
    #1;
    check("latency_early.an", 32'(an), 32'(4'b1111));
    @(posedge clock_in);
    #1;
    check("latency_on_time.an", 32'(an), 32'(4'b1110));
    check("latency_on_time.seg", 32'(seg), 32'(7'h19));
    @(negedge clock_in);
    scan_clk = 1'b0;
    repeat (SYNC + 1) @(posedge clock_in);

    // Vector table: two full frames per record.
    for (int v = 0; v < 7; v++) begin
      go_idle($sformatf("vec%0d.idle", v));
      start_frame(vecs[v].value, vecs[v].blz, vecs[v].dp_en);
      for (int f = 0; f < 2; f++) begin
        for (int k = 0; k < 4; k++) begin
          push_exp(an_for(k), vecs[v].seg_exp[k], vecs[v].dp_exp[k]);
          scan_edge($sformatf("vec%0d.f%0d.d%0d", v, f, k));
        end
      end
    end

    // Live value change mid-frame must not tear; new value appears after the wrap.
    go_idle("tear.idle");
    start_frame(16'h1111, 1'b0, 4'b0000);
    push_exp(4'b1110, 7'h79, 1'b1); scan_edge("tear.d0");
    push_exp(4'b1101, 7'h79, 1'b1); scan_edge("tear.d1");
    @(negedge clock_in);
    value = 16'h2222;
    push_exp(4'b1011, 7'h79, 1'b1); scan_edge("tear.d2");
    push_exp(4'b0111, 7'h79, 1'b1); scan_edge("tear.d3");
    push_exp(4'b1110, 7'h24, 1'b1); scan_edge("tear.wrap_d0");
    push_exp(4'b1101, 7'h24, 1'b1); scan_edge("tear.wrap_d1");

    // Reset mid-scan at idx 2 blanks between clock edges.
    go_idle("rst.idle");
    start_frame(16'h1234, 1'b0, 4'b0000);
    push_exp(4'b1110, 7'h19, 1'b1); scan_edge("rst.d0");
    push_exp(4'b1101, 7'h30, 1'b1); scan_edge("rst.d1");
    push_exp(4'b1011, 7'h24, 1'b1); scan_edge("rst.d2");
    @(posedge clock_in);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async.an", 32'(an), 32'(4'b1111));
    check("rst_async.seg", 32'(seg), 32'(7'h7F));
    check("rst_async.dp", 32'(dp), 32'(1'b1));
    value = 16'h5678;
    repeat (2) @(posedge clock_in);
    @(negedge clock_in);
    reset = 1'b0;
    repeat (2) @(posedge clock_in);
    push_exp(4'b1110, 7'h00, 1'b1); scan_edge("rst.restart_d0");

    // Enable dropped in the same cycle as a tick: IDLE wins.
    @(negedge clock_in);
    scan_clk = 1'b1;
    repeat (SYNC) @(posedge clock_in);
    @(negedge clock_in);
    enable = 1'b0;
    @(posedge clock_in);
    #1;
    check("en_drop.lag_an", 32'(an), 32'(4'b1110));
    @(posedge clock_in);
    #1;
    check("en_drop.idle_an", 32'(an), 32'(4'b1111));
    check("en_drop.idle_seg", 32'(seg), 32'(7'h7F));
    @(negedge clock_in);
    scan_clk = 1'b0;
    enable   = 1'b1;
    repeat (SYNC + 1) @(posedge clock_in);

    // scan_clk held high, then low, for 100 cycles: no extra steps.
    push_exp(4'b1110, 7'h00, 1'b1); scan_edge("hold.d0");
    @(negedge clock_in);
    scan_clk = 1'b1;
    push_exp(4'b1101, 7'h78, 1'b1);
    repeat (LAT) @(posedge clock_in);
    #1;
    compare_out("hold.d1");
    repeat (100) @(posedge clock_in);
    #1;
    check("hold_high.an", 32'(an), 32'(4'b1101));
    @(negedge clock_in);
    scan_clk = 1'b0;
    repeat (100) @(posedge clock_in);
    #1;
    check("hold_low.an", 32'(an), 32'(4'b1101));
    push_exp(4'b1011, 7'h02, 1'b1); scan_edge("hold.d2");

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
